// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch / load / store sequencer for the RV32I core.
// Drives the IMEM and DMEM AXI valid/ready handshakes, latches the fetched
// instruction and load data, and issues the one-cycle PC_EN / REG_WE commit strobes.
// Addresses and write data flow from the datapath straight to AXI, not through here.
//
// Ports:
//   CLK, NRST                     clock, synchronous active-low reset
//   IMEM_AR*/IMEM_R*              instruction fetch read channels
//   DMEM_AR*/DMEM_R*              load read channels
//   DMEM_AW*/DMEM_W*/DMEM_B*      store write channels
//   IS_LOAD/IS_STORE/IS_ILLEGAL/RD_WE  decode of INSTR, sampled in EXEC
//   INSTR, LOAD_DATA              latched instruction word and load data
//   PC_EN, REG_WE, WB_SEL_LOAD    commit strobes and write-back select
//   TRAP                          sticky fault indicator
//   RETIRED                       committed-instruction counter (wraps)
module core_sequencer #(
  parameter int unsigned AXI_DWIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  NRST,
  output logic                  IMEM_ARVALID,
  input  logic                  IMEM_ARREADY,
  input  logic [AXI_DWIDTH-1:0] IMEM_RDATA,
  input  logic [1:0]            IMEM_RRESP,
  input  logic                  IMEM_RVALID,
  output logic                  IMEM_RREADY,
  output logic                  DMEM_ARVALID,
  input  logic                  DMEM_ARREADY,
  input  logic [AXI_DWIDTH-1:0] DMEM_RDATA,
  input  logic [1:0]            DMEM_RRESP,
  input  logic                  DMEM_RVALID,
  output logic                  DMEM_RREADY,
  output logic                  DMEM_AWVALID,
  input  logic                  DMEM_AWREADY,
  output logic                  DMEM_WVALID,
  input  logic                  DMEM_WREADY,
  input  logic [1:0]            DMEM_BRESP,
  input  logic                  DMEM_BVALID,
  output logic                  DMEM_BREADY,
  input  logic                  IS_LOAD,
  input  logic                  IS_STORE,
  input  logic                  IS_ILLEGAL,
  input  logic                  RD_WE,
  output logic [31:0]           INSTR,
  output logic [AXI_DWIDTH-1:0] LOAD_DATA,
  output logic                  PC_EN,
  output logic                  REG_WE,
  output logic                  WB_SEL_LOAD,
  output logic                  TRAP,
  output logic [CNT_WIDTH-1:0]  RETIRED
);

  typedef enum logic [3:0] {
    StIfa, StIfr, StExec, StLda, StLdr, StWb, StStw, StStb, StTrap
  } state_e;

  state_e                state_q, state_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [31:0]           instr_q, instr_d;
  logic [AXI_DWIDTH-1:0] load_data_q, load_data_d;
  logic [CNT_WIDTH-1:0]  retired_q;

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q     <= StIfa;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      instr_q     <= '0;
      load_data_q <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      instr_q     <= instr_d;
      load_data_q <= load_data_d;
      if (PC_EN) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    instr_d      = instr_q;
    load_data_d  = load_data_q;
    IMEM_ARVALID = 1'b0;
    IMEM_RREADY  = 1'b0;
    DMEM_ARVALID = 1'b0;
    DMEM_RREADY  = 1'b0;
    DMEM_AWVALID = 1'b0;
    DMEM_WVALID  = 1'b0;
    DMEM_BREADY  = 1'b0;
    PC_EN        = 1'b0;
    REG_WE       = 1'b0;
    WB_SEL_LOAD  = 1'b0;
    TRAP         = 1'b0;

    unique case (state_q)
      StIfa: begin
        IMEM_ARVALID = 1'b1;
        if (IMEM_ARREADY) state_d = StIfr;
      end
      StIfr: begin
        IMEM_RREADY = 1'b1;
        if (IMEM_RVALID) begin
          // Latched even on an error response so the faulting word is visible.
          instr_d = IMEM_RDATA[31:0];
          state_d = (IMEM_RRESP != 2'b00) ? StTrap : StExec;
        end
      end
      StExec: begin
        if (IS_ILLEGAL || (IS_LOAD && IS_STORE)) begin
          state_d = StTrap;
        end else if (IS_LOAD) begin
          state_d = StLda;
        end else if (IS_STORE) begin
          state_d = StStw;
        end else begin
          PC_EN   = 1'b1;
          REG_WE  = RD_WE;
          state_d = StIfa;
        end
      end
      StLda: begin
        DMEM_ARVALID = 1'b1;
        if (DMEM_ARREADY) state_d = StLdr;
      end
      StLdr: begin
        DMEM_RREADY = 1'b1;
        if (DMEM_RVALID) begin
          load_data_d = DMEM_RDATA;
          state_d     = (DMEM_RRESP != 2'b00) ? StTrap : StWb;
        end
      end
      StWb: begin
        REG_WE      = RD_WE;
        WB_SEL_LOAD = 1'b1;
        PC_EN       = 1'b1;
        state_d     = StIfa;
      end
      StStw: begin
        // AW and W complete independently; leave once both have, in any order.
        DMEM_AWVALID = !aw_done_q;
        DMEM_WVALID  = !w_done_q;
        aw_done_d    = aw_done_q || DMEM_AWREADY;
        w_done_d     = w_done_q || DMEM_WREADY;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StStb;
        end
      end
      StStb: begin
        DMEM_BREADY = 1'b1;
        if (DMEM_BVALID) begin
          if (DMEM_BRESP != 2'b00) begin
            state_d = StTrap;
          end else begin
            PC_EN   = 1'b1;
            state_d = StIfa;
          end
        end
      end
      StTrap: begin
        TRAP = 1'b1;
      end
      default: begin
        state_d = StTrap;
      end
    endcase

    // Handshake and strobe outputs are held low for the whole reset period.
    if (!NRST) begin
      IMEM_ARVALID = 1'b0;
      IMEM_RREADY  = 1'b0;
      DMEM_ARVALID = 1'b0;
      DMEM_RREADY  = 1'b0;
      DMEM_AWVALID = 1'b0;
      DMEM_WVALID  = 1'b0;
      DMEM_BREADY  = 1'b0;
      PC_EN        = 1'b0;
      REG_WE       = 1'b0;
      WB_SEL_LOAD  = 1'b0;
      TRAP         = 1'b0;
    end
  end

  assign INSTR     = instr_q;
  assign LOAD_DATA = load_data_q;
  assign RETIRED   = retired_q;

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle instruction sequencer for the RV32I core. It drives the IMEM and host/DMEM AXI valid/ready handshakes for fetch, load and store, and latches the fetched instruction and load data. It also issues the single-cycle PC-update and register-write strobes that commit each instruction. It sits between the AXI ports of `core_top` and the combinational control, ALU and register-file datapath; address and write-data buses pass from the datapath straight to AXI and are not routed through this block.

## Interface
- `AXI_DWIDTH`, default 32: data width of both AXI interfaces.
- `CNT_WIDTH`, default 32: width of the retired-instruction counter.

- `CLK`  in  1  clock, all logic on the rising edge.
- `NRST`  in  1  reset, synchronous, active-low.
- `IMEM_ARVALID`/`IMEM_ARREADY`  out/in  1  instruction fetch address handshake.
- `IMEM_RDATA`  in  `AXI_DWIDTH`  instruction word.
- `IMEM_RRESP`  in  2  instruction read response.
- `IMEM_RVALID`/`IMEM_RREADY`  in/out  1  instruction read data handshake.
- `DMEM_ARVALID`/`DMEM_ARREADY`  out/in  1  load address handshake.
- `DMEM_RDATA`  in  `AXI_DWIDTH`  load data.
- `DMEM_RRESP`  in  2  load response.
- `DMEM_RVALID`/`DMEM_RREADY`  in/out  1  load data handshake.
- `DMEM_AWVALID`/`DMEM_AWREADY`  out/in  1  store address handshake.
- `DMEM_WVALID`/`DMEM_WREADY`  out/in  1  store data handshake.
- `DMEM_BRESP`  in  2  store write response.
- `DMEM_BVALID`/`DMEM_BREADY`  in/out  1  store response handshake.
- `IS_LOAD`, `IS_STORE`, `IS_ILLEGAL`, `RD_WE`  in  1 each  decode of the `INSTR` output, valid in EXEC.
- `INSTR`  out  32  latched instruction word.
- `LOAD_DATA`  out  `AXI_DWIDTH`  latched load data.
- `PC_EN`  out  1  one-cycle strobe: PC register loads its next value.
- `REG_WE`  out  1  one-cycle strobe: register file writes `rd`.
- `WB_SEL_LOAD`  out  1  high in WB: write-back source is `LOAD_DATA`.
- `TRAP`  out  1  sticky fault indicator.
- `RETIRED`  out  `CNT_WIDTH`  committed-instruction count.

## Operation
- States: IFA, IFR, EXEC, LDA, LDR, WB, STW, STB, TRAP. All VALID/READY and strobe outputs decode combinationally from the state and handshake flags.
- **IFA:** `IMEM_ARVALID`=1. On `IMEM_ARREADY`, go to IFR.
- **IFR:** `IMEM_RREADY`=1. On `IMEM_RVALID`:
  - always latch `INSTR` <= `IMEM_RDATA`;
  - if `IMEM_RRESP`≠0, go to TRAP; otherwise go to EXEC.
- **EXEC** (exactly 1 cycle):
  - `IS_ILLEGAL`, or `IS_LOAD` and `IS_STORE` together: go to TRAP.
  - `IS_LOAD`: go to LDA.
  - `IS_STORE`: go to STW.
  - otherwise: `PC_EN`=1, `REG_WE`=`RD_WE`, go to IFA.
- **LDA:** `DMEM_ARVALID`=1. On `DMEM_ARREADY`, go to LDR.
- **LDR:** `DMEM_RREADY`=1. On `DMEM_RVALID`:
  - latch `LOAD_DATA`;
  - if `DMEM_RRESP`≠0, go to TRAP; otherwise go to WB.
- **WB** (1 cycle): `REG_WE`=`RD_WE`, `WB_SEL_LOAD`=1, `PC_EN`=1, go to IFA.
- **STW:**
  - `DMEM_AWVALID`=!aw_done and `DMEM_WVALID`=!w_done.
  - aw_done and w_done are set on their own handshake, so the AW and W handshakes may complete in either order or in the same cycle.
  - Once both are done (including the cycle the second completes), go to STB and clear both flags.
- **STB:** `DMEM_BREADY`=1. On `DMEM_BVALID`:
  - if `DMEM_BRESP`≠0, go to TRAP;
  - otherwise `PC_EN`=1 in that same cycle, go to IFA.
- **TRAP:** terminal. `TRAP`=1, no VALIDs, no strobes. Only `NRST` exits.
- A nonzero response never produces `PC_EN` or `REG_WE`.
- `RETIRED` increments on every `PC_EN` and wraps from all-ones to 0.
- The PC and register file change only on `PC_EN`/`REG_WE`, so datapath-driven AXI addresses and data stay stable while VALID is high.

## Timing
- **Reset:**
  - state=IFA, aw_done=w_done=0, `INSTR`=0, `LOAD_DATA`=0, `RETIRED`=0, `TRAP`=0.
  - All strobes and VALID/READY outputs read 0 while `NRST`=0.
  - `IMEM_ARVALID`=1 in the first cycle with `NRST`=1.
- **Reset mid-transaction:** on the next edge the state returns to IFA and any outstanding AXI transfer is abandoned. The bench resets the slaves together with the core.
- **VALID rules:** once asserted, a VALID stays high until its handshake. VALIDs never depend combinationally on READY.
- **Zero-wait slaves** (READY always 1, R/B returned 1 cycle after the address handshake):
  - ALU instruction: 3 cycles (IFA, IFR, EXEC).
  - Load: 6 cycles (IFA, IFR, EXEC, LDA, LDR, WB).
  - Store: 5 cycles (IFA, IFR, EXEC, STW, STB).
- Each wait state on any channel adds exactly 1 cycle.
- `PC_EN` and `REG_WE` are never high for more than 1 cycle per instruction.

## Test plan
- **Reset, then ALU op:** release `NRST` with `IMEM_RDATA`=0x00500093 and `RD_WE`=1 → `IMEM_ARVALID` in cycle 0; `PC_EN` and `REG_WE` in cycle 2; `INSTR`=0x00500093; `RETIRED`=1.
- **Load with stalls:** `DMEM_ARREADY` delayed 2 cycles, `DMEM_RDATA`=0xDEADBEEF → `LOAD_DATA`=0xDEADBEEF; `REG_WE` and `WB_SEL_LOAD` high together for 1 cycle; total 8 cycles.
- **Store ordering:** W ready 3 cycles before AW, then repeat with both ready in the same cycle → `DMEM_WVALID` drops after its handshake while `DMEM_AWVALID` stays high; `PC_EN` only on `DMEM_BVALID`; total 5 cycles plus stalls.
- **Error response:** `DMEM_BRESP`=2'b10 → `TRAP`=1; no `PC_EN`; `RETIRED` unchanged; `IMEM_ARVALID` stays 0 for 20 cycles.
- **Illegal instruction, and `IS_LOAD`=`IS_STORE`=1** → TRAP from EXEC with no DMEM VALIDs.
- **Reset mid-LDR:** pull `NRST` low → all outputs 0 after 1 edge; fetch restarts; preload `RETIRED`=0xFFFFFFFF (via a forced run) then retire 1 → wraps to 0.
